// File: rtl/branch_redirect_ctrl.sv
// EX-stage redirect/flush sequencer: registered PC redirect and IF/ID, ID/EX squash after mispredicts and jumps.
// Optional performance counters enabled by defining PERF_CNT_EN.
module branch_redirect_ctrl #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jump,
   input  logic             ex_br_taken,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic [XLEN-1:0]  ex_pc_plus4,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             busy,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   // state | meaning
   // IDLE  | watching EX for mispredicts/jumps, outputs quiet
   // PEND  | redirect captured, waiting for stall to drop
   // FLUSH | redirect pulse on first cycle, squash wrong-path stages
   typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

   localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t          state_q, state_d;
   logic [2:0]      fcnt_q, fcnt_d;
   logic [XLEN-1:0] held_pc_q, held_pc_d;
   logic [XLEN-1:0] pc_load;
   logic [XLEN-1:0] correct_pc;
   logic            mispredict;
   logic            enter_flush;

   assign mispredict = ex_valid & (ex_is_jump |
                       (ex_is_branch & (ex_br_taken != ex_pred_taken)));
   assign correct_pc = (ex_is_jump | ex_br_taken) ? ex_target : ex_pc_plus4;

   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      held_pc_d   = held_pc_q;
      enter_flush = 1'b0;
      pc_load     = '0;
      case (state_q)
         IDLE: begin
            if (mispredict) begin
               held_pc_d = correct_pc;
               if (stall) begin
                  state_d = PEND;
               end else begin
                  state_d     = FLUSH;
                  enter_flush = 1'b1;
                  fcnt_d      = FC_LOAD;
                  pc_load     = correct_pc;
               end
            end
         end
         PEND: begin
            if (!stall) begin
               state_d     = FLUSH;
               enter_flush = 1'b1;
               fcnt_d      = FC_LOAD;
               pc_load     = held_pc_q;
            end
         end
         FLUSH: begin
            // flush length only advances on cycles the pipeline actually moves
            if (!stall) begin
               if (fcnt_q == 3'd0) state_d = IDLE;
               else                fcnt_d  = fcnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         fcnt_q         <= '0;
         held_pc_q      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_if_id    <= 1'b0;
         flush_id_ex    <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_q        <= state_d;
         fcnt_q         <= fcnt_d;
         held_pc_q      <= held_pc_d;
         redirect_valid <= enter_flush;
         redirect_pc    <= pc_load;
         flush_if_id    <= (state_d == FLUSH);
         flush_id_ex    <= (state_d == FLUSH);
         busy           <= (state_d != IDLE);
      end
   end

`ifdef PERF_CNT_EN
   logic resolve_acc;
   assign resolve_acc = (state_q == IDLE) & ~stall & ex_valid & (ex_is_branch | ex_is_jump);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt      <= '0;
         mispred_cnt <= '0;
      end else begin
         if (resolve_acc && (br_cnt != '1))      br_cnt      <= br_cnt + 1'b1;
         if (enter_flush && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
      end
   end
`else
   assign br_cnt      = '0;
   assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl (CNT_W=4 so counter saturation is reachable).
module tb_branch_redirect_ctrl;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stall, ex_valid, ex_is_branch, ex_is_jump, ex_br_taken, ex_pred_taken;
   logic [XLEN-1:0]  ex_target, ex_pc_plus4;
   logic             redirect_valid, flush_if_id, flush_id_ex, busy;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] br_cnt, mispred_cnt;

   int total = 0;
   int bad   = 0;
   logic [3:0] mb = '0;
   logic [3:0] mm = '0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_br_taken(ex_br_taken),
      .ex_pred_taken(ex_pred_taken), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
      .flush_id_ex(flush_id_ex), .busy(busy), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic rv, input logic [31:0] pc,
                       input logic fl, input logic by);
      chk({tag, ".rv"},    32'(redirect_valid), 32'(rv));
      chk({tag, ".pc"},    redirect_pc,         pc);
      chk({tag, ".ifid"},  32'(flush_if_id),    32'(fl));
      chk({tag, ".idex"},  32'(flush_id_ex),    32'(fl));
      chk({tag, ".busy"},  32'(busy),           32'(by));
   endtask

   task automatic cnts(input string tag);
      chk({tag, ".br_cnt"},  32'(br_cnt),      PERF ? 32'(mb) : 32'd0);
      chk({tag, ".mis_cnt"}, 32'(mispred_cnt), PERF ? 32'(mm) : 32'd0);
   endtask

   function automatic logic [3:0] inc(input logic [3:0] v);
      return (v == 4'hf) ? v : v + 4'd1;
   endfunction

   task automatic drv(input logic v, input logic isb, input logic isj, input logic tk,
                      input logic pr, input logic [31:0] tgt, input logic [31:0] p4,
                      input logic st);
      ex_valid = v; ex_is_branch = isb; ex_is_jump = isj; ex_br_taken = tk;
      ex_pred_taken = pr; ex_target = tgt; ex_pc_plus4 = p4; stall = st;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      #2;
      outs("reset", 0, 32'h0, 0, 0);
      cnts("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // BEQ predicted not-taken but taken
      drv(1, 1, 0, 1, 0, 32'h100, 32'h0c4, 0);
      mb = inc(mb); mm = inc(mm);
      tick(); outs("beq_n1", 1, 32'h100, 1, 1);
      idle();
      tick(); outs("beq_n2", 0, 32'h0, 1, 1);
      tick(); outs("beq_n3", 0, 32'h0, 0, 0);
      cnts("beq");

      // BNE predicted taken, resolved not-taken
      drv(1, 1, 0, 0, 1, 32'h80, 32'h44, 0);
      mb = inc(mb); mm = inc(mm);
      tick(); outs("bne_n1", 1, 32'h44, 1, 1);
      idle();
      tick(); tick(); outs("bne_n3", 0, 32'h0, 0, 0);

      // correctly predicted taken branch held for 3 cycles
      drv(1, 1, 0, 1, 1, 32'h500, 32'h48, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); outs("corr", 0, 32'h0, 0, 0);
         mb = inc(mb);
      end
      idle();
      cnts("corr");

      // JAL under stall: PEND, later target ignored
      drv(1, 0, 1, 0, 0, 32'h200, 32'h10, 1);
      tick(); outs("pend1", 0, 32'h0, 0, 1);
      drv(1, 0, 1, 0, 0, 32'h999, 32'h14, 1);
      tick(); outs("pend2", 0, 32'h0, 0, 1);
      tick(); outs("pend3", 0, 32'h0, 0, 1);
      stall = 1'b0;
      mm = inc(mm);
      tick(); outs("jal_fl1", 1, 32'h200, 1, 1);
      idle();
      tick(); outs("jal_fl2", 0, 32'h0, 1, 1);
      tick(); outs("jal_done", 0, 32'h0, 0, 0);
      cnts("jal");

      // second mispredict presented during first FLUSH cycle
      drv(1, 1, 0, 1, 0, 32'h100, 32'h20, 0);
      mb = inc(mb); mm = inc(mm);
      tick(); outs("dbl1", 1, 32'h100, 1, 1);
      drv(1, 1, 0, 1, 0, 32'h300, 32'h24, 0);
      tick(); outs("dbl2", 0, 32'h0, 1, 1);
      idle();
      tick(); outs("dbl3", 0, 32'h0, 0, 0);
      cnts("dbl");

      // stall during FLUSH stretches the flush window
      drv(1, 1, 0, 0, 1, 32'h700, 32'h60, 0);
      mb = inc(mb); mm = inc(mm);
      tick(); outs("fst1", 1, 32'h60, 1, 1);
      drv(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
      tick(); outs("fst2", 0, 32'h0, 1, 1);
      stall = 1'b0;
      tick(); outs("fst3", 0, 32'h0, 1, 1);
      tick(); outs("fst4", 0, 32'h0, 0, 0);
      cnts("fst");

      // reset asserted in the second FLUSH cycle
      drv(1, 1, 0, 1, 0, 32'h140, 32'h30, 0);
      tick(); outs("rmid1", 1, 32'h140, 1, 1);
      idle();
      tick(); outs("rmid2", 0, 32'h0, 1, 1);
      rst_n = 1'b0;
      #1;
      outs("rmid_rst", 0, 32'h0, 0, 0);
      mb = '0; mm = '0;
      cnts("rmid_rst");
      #1 rst_n = 1'b1;
      drv(1, 1, 0, 0, 0, 32'h800, 32'h34, 0);
      mb = inc(mb);
      tick(); outs("rmid_c1", 0, 32'h0, 0, 0);
      idle();
      tick(); outs("rmid_c2", 0, 32'h0, 0, 0);
      cnts("rmid_c");

      // 20 resolved branches, 3 mispredicted: br_cnt saturates at 15
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      mb = '0; mm = '0;
      for (int i = 0; i < 20; i++) begin
         if (i == 4 || i == 9 || i == 14) begin
            drv(1, 1, 0, 1, 0, 32'h400 + 32'(i * 4), 32'h0, 0);
            mb = inc(mb); mm = inc(mm);
            tick(); chk("sat.rv", 32'(redirect_valid), 32'd1);
            idle();
            tick(); tick();
         end else begin
            drv(1, 1, 0, 0, 0, 32'h600, 32'h0, 0);
            mb = inc(mb);
            tick();
         end
      end
      idle();
      tick(); outs("sat_end", 0, 32'h0, 0, 0);
      cnts("sat");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences pipeline redirection after branch and jump resolution in the EX stage of the pipelined RV32 core. Consumes the branch-taken decision from the branch control unit and the ID-stage prediction bit. Detects mispredictions and unconditional jumps, issues a registered PC redirect, and flushes wrong-path instructions from the IF/ID and ID/EX registers. Sits between the branch control unit, the hazard unit (stall) and the PC/pipeline-register logic.

Parameters:
XLEN, 32, address width of target/redirect PC
FLUSH_CYCLES, 2, cycles flush outputs stay asserted after redirect (1..7)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard-unit stall; pipeline frozen this cycle
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_is_jump  in  1  EX instruction is JAL/JALR
ex_br_taken  in  1  branch outcome from branch control unit
ex_pred_taken  in  1  prediction made at fetch for this instruction
ex_target  in  XLEN  computed taken target
ex_pc_plus4  in  XLEN  fall-through address
redirect_valid  out  1  one-cycle pulse: PC loads redirect_pc
redirect_pc  out  XLEN  corrected fetch address
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
busy  out  1  controller not in IDLE
br_cnt  out  CNT_W  resolved branch+jump count (optional feature)
mispred_cnt  out  CNT_W  redirect count (optional feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; flush counter 0; held target 0. Deassertion takes effect at next rising edge.
- resolve = ex_valid & (ex_is_branch | ex_is_jump); evaluated only in IDLE.
- mispredict = ex_valid & (ex_is_jump | (ex_is_branch & (ex_br_taken != ex_pred_taken))).
- Correct PC: ex_target if (ex_is_jump | ex_br_taken), else ex_pc_plus4. Passed through unmodified (no alignment masking).
- If ex_is_jump and ex_is_branch are both 1, the instruction is treated as a jump.
- States:
  - IDLE: outputs 0. On mispredict & ~stall, capture PC and go to FLUSH. On mispredict & stall, capture PC and go to PEND.
  - PEND: hold captured PC and ignore all ex_* inputs. When stall=0, go to FLUSH.
  - FLUSH: redirect_valid=1 only in the first FLUSH cycle; redirect_pc=captured PC for that cycle (0 otherwise).
    - flush_if_id=flush_id_ex=1 for FLUSH_CYCLES cycles, counted only on cycles with stall=0; the counter freezes while stall=1 and the flush outputs stay asserted.
    - The redirect pulse also waits on stall=0, because FLUSH is only entered with stall=0.
    - After the last counted cycle, return to IDLE.
    - ex_* inputs are ignored in FLUSH (wrong path).
- Latency: mispredict seen in cycle N with stall=0 gives redirect_valid and flushes in cycle N+1.
- busy=1 in PEND and FLUSH.
- A correctly predicted branch causes no state change, no flush and no redirect.
- All outputs are registered (driven from flops), so there is no combinational path from ex_* to outputs.

Optional Feature:
PERF_CNT_EN:
- Defined: br_cnt increments once per resolve accepted in IDLE with stall=0; mispred_cnt increments once per entry to FLUSH.
- Both counters saturate at all-ones and reset to 0.
- Undefined: br_cnt and mispred_cnt are tied to 0 and no counter flops are synthesized. Port list is unchanged.

Test Plan:
- Reset mid-FLUSH: rst_n=0 in the 2nd FLUSH cycle -> all outputs 0 immediately; state IDLE; next correct branch causes no flush.
- BEQ predicted not-taken, ex_br_taken=1, ex_target=0x0000_0100, stall=0 at cycle N:
  - cycle N+1: redirect_valid=1, redirect_pc=0x100, both flushes=1;
  - cycle N+2: flushes=1, redirect_valid=0;
  - cycle N+3: all 0, busy=0.
- BNE predicted taken, resolved not-taken, ex_pc_plus4=0x0000_0044 -> redirect_pc=0x44 one cycle later; correctly predicted branch (taken==pred) -> no outputs asserted for 3 cycles.
- JAL with ex_target=0x200 and stall=1 for 3 cycles -> PEND for 3 cycles, redirect_valid=0; first cycle stall=0 -> FLUSH with redirect_pc=0x200. A different ex_target presented during PEND is ignored.
- Second mispredicting branch in the first FLUSH cycle (target 0x300) -> ignored: no second redirect_valid pulse; mispred_cnt=1.
- PERF_CNT_EN defined, CNT_W=4: 20 resolved branches of which 3 mispredict -> br_cnt=15 (saturated), mispred_cnt=3. Macro undefined -> both read 0.
